ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port RAM between two requesters: the CPU memory path (MAR/RAM control signals) and an external program loader/debug port.
- Arbitrates per access and sequences each access as a fixed two-cycle transaction.
- Returns read data with a one-cycle ack pulse and tells the control unit when the CPU is stalled.
- Sits between the CPU core and the ram instance.

Parameters:
- DATA_WIDTH, 8, RAM word width (same as arch_defs_pkg DATA_WIDTH).
- ADDR_WIDTH, 4, RAM address width (same as arch_defs_pkg ADDR_WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_req  input  1  CPU access request; held with addr/we/wdata stable until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_WIDTH  CPU address.
- cpu_wdata  input  DATA_WIDTH  CPU write data.
- cpu_rdata  output  DATA_WIDTH  read data; valid only while cpu_ack = 1, else 0.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_stall  output  1  cpu_req & ~cpu_ack; the control unit freezes its microstep while this is high.
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack  same widths and semantics as the CPU set.
- loader_mode  input  1  when 1, CPU requests are never granted.
- ram_we  output  1  RAM write enable.
- ram_addr  output  ADDR_WIDTH  RAM address.
- ram_wdata  output  DATA_WIDTH  RAM write data.
- ram_rdata  input  DATA_WIDTH  RAM synchronous read data (1-cycle latency).
- grant  output  2  current owner: 00 none, 01 CPU, 10 loader.

Behaviour:
- **Reset** (reset = 0, async): state = S_IDLE, last_grant = LDR. All acks = 0, rdata outputs = 0, ram_we = 0 (forced while reset is asserted), grant = 00.
- **States:** S_IDLE, S_CPU, S_LDR.
- **S_IDLE, arbitration:**
  - Eligible set: cpu_req & ~loader_mode, and ldr_req.
  - One eligible requester: it wins.
  - Both eligible: the requester not equal to last_grant wins (round-robin).
  - Tie-break after reset: CPU wins the first tie.
  - Winner's addr/wdata/we drive ram_* combinationally in this cycle; the write commits at this edge.
  - Next state: S_CPU or S_LDR; last_grant updates to the winner.
  - No eligible requester: ram_we = 0, ram_addr = 0, stay in S_IDLE.
- **S_CPU / S_LDR:**
  - Owner's ack = 1.
  - Owner's rdata = ram_rdata if it was a read, 0 for a write.
  - ram_we = 0. Next state: S_IDLE unconditionally.
- **Throughput and latency:**
  - Minimum 2 cycles per access; request seen in cycle N → ack in cycle N+1.
  - A requester holding req high after ack re-arbitrates in the following S_IDLE cycle.
- **Commit rules:**
  - A transaction is committed at the S_IDLE edge.
  - Dropping req during S_CPU/S_LDR still produces the ack; the write is already performed.
- **loader_mode:**
  - Asserting it while in S_CPU does not abort; the CPU ack still fires.
  - Subsequent CPU requests stall indefinitely with cpu_stall = 1.
- **grant:** 01 in S_CPU, 10 in S_LDR, 00 in S_IDLE.
- **Reset mid-transaction:** the pending ack is lost and the requester must re-request.
- **Address width:** no wrap or overflow arithmetic; addresses pass through unchanged at ADDR_WIDTH.

Optional Feature:
- Macro: RAM_ARBITER_PERF_COUNT_EN.
- **When defined:**
  - Adds outputs cpu_grant_count[15:0] and ldr_grant_count[15:0], plus input count_clear.
  - A counter increments on each transition out of S_IDLE to its owner.
  - Counters saturate at 16'hFFFF.
  - Counters clear on reset or on count_clear = 1; clear wins over a simultaneous increment.
- **When undefined:** the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- arch_defs_pkg gains:
  - arb_state_t enum {S_IDLE, S_CPU, S_LDR};
  - arb_owner_t enum {OWNER_NONE = 2'b00, OWNER_CPU = 2'b01, OWNER_LDR = 2'b10}, used for the grant encoding.
- One natural sub-module: arb_rr_picker.
  - Inputs: two eligible bits and last_grant.
  - Output: the winner, combinational.
  - Kept separate so the fairness rule can be unit-tested alone.

Test Plan:
- Reset released, cpu_req = 1, we = 1, addr = 4'h3, wdata = 8'hA5 → grant = 01 next cycle, cpu_ack pulse, RAM[3] = A5; then a CPU read of addr 3 → cpu_rdata = A5 on the ack cycle.
- Both requesting continuously from reset → grants alternate CPU, LDR, CPU, LDR; each ack arrives every 4 cycles per requester.
- loader_mode = 1 with cpu_req held → cpu_stall = 1 and no cpu_ack for 20 cycles; a loader write of 8'h3C to addr F succeeds; deassert loader_mode → CPU granted within 2 cycles.
- cpu_req dropped in S_CPU during a write of 8'h11 → cpu_ack still pulses and RAM holds 11.
- reset asserted in S_LDR → ldr_ack = 0, grant = 00 and ram_we = 0 immediately (asynchronously).
- With RAM_ARBITER_PERF_COUNT_EN: 5 CPU and 3 loader accesses → counts 5 and 3; count_clear coincident with a grant → count 0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
//------------------------------------------------------------------------------
// ram_arbiter_pkg : shared types for the RAM arbiter (FSM states, owner codes).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_LDR  = 2'd2
    } arb_state_t;

    // Owner codes double as the external grant encoding.
    typedef enum logic [1:0] {
        OWNER_NONE = 2'b00,
        OWNER_CPU  = 2'b01,
        OWNER_LDR  = 2'b10
    } arb_owner_t;

    localparam int CNT_WIDTH = 16;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_picker.sv
//------------------------------------------------------------------------------
// arb_rr_picker : two-way round-robin winner selection, purely combinational.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_rr_picker
    import ram_arbiter_pkg::*;
(
    input  logic       cpu_eligible,
    input  logic       ldr_eligible,
    input  logic [1:0] last_grant,
    output logic [1:0] winner
);

    always_comb begin
        winner = OWNER_NONE;
        if (cpu_eligible && ldr_eligible) begin
            // On a tie the side that did not win last time goes first.
            winner = (last_grant == OWNER_CPU) ? OWNER_LDR : OWNER_CPU;
        end else if (cpu_eligible) begin
            winner = OWNER_CPU;
        end else if (ldr_eligible) begin
            winner = OWNER_LDR;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
//------------------------------------------------------------------------------
// ram_arbiter : shares a single-port sync RAM between CPU and loader ports
//               using two-cycle transactions. Optional RAM_ARBITER_PERF_COUNT_EN
//               adds saturating per-requester grant counters.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_stall,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    output logic                  ldr_ack,
    input  logic                  loader_mode,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
`ifdef RAM_ARBITER_PERF_COUNT_EN
    input  logic                  count_clear,
    output logic [CNT_WIDTH-1:0]  cpu_grant_count,
    output logic [CNT_WIDTH-1:0]  ldr_grant_count,
`endif
    output logic [1:0]            grant
);

    arb_state_t state;
    logic [1:0] last_grant;
    logic [1:0] winner;
    logic       txn_we;

    arb_rr_picker u_picker (
        .cpu_eligible (cpu_req & ~loader_mode),
        .ldr_eligible (ldr_req),
        .last_grant   (last_grant),
        .winner       (winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            last_grant <= OWNER_LDR;
            txn_we     <= 1'b0;
            grant      <= OWNER_NONE;
            cpu_ack    <= 1'b0;
            ldr_ack    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (winner == OWNER_CPU) begin
                        state      <= S_CPU;
                        last_grant <= OWNER_CPU;
                        txn_we     <= cpu_we;
                        grant      <= OWNER_CPU;
                        cpu_ack    <= 1'b1;
                    end else if (winner == OWNER_LDR) begin
                        state      <= S_LDR;
                        last_grant <= OWNER_LDR;
                        txn_we     <= ldr_we;
                        grant      <= OWNER_LDR;
                        ldr_ack    <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    grant   <= OWNER_NONE;
                    cpu_ack <= 1'b0;
                    ldr_ack <= 1'b0;
                end
            endcase
        end
    end

    // The RAM is only driven in S_IDLE; the write lands on the arbitration edge.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state == S_IDLE) begin
            if (winner == OWNER_CPU) begin
                ram_we    = cpu_we;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
            end else if (winner == OWNER_LDR) begin
                ram_we    = ldr_we;
                ram_addr  = ldr_addr;
                ram_wdata = ldr_wdata;
            end
        end
        ram_we = ram_we & reset;
    end

    assign cpu_rdata = (cpu_ack && !txn_we) ? ram_rdata : '0;
    assign ldr_rdata = (ldr_ack && !txn_we) ? ram_rdata : '0;
    assign cpu_stall = cpu_req & ~cpu_ack;

`ifdef RAM_ARBITER_PERF_COUNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_grant_count <= '0;
            ldr_grant_count <= '0;
        end else if (count_clear) begin
            cpu_grant_count <= '0;
            ldr_grant_count <= '0;
        end else if (state == S_IDLE) begin
            if (winner == OWNER_CPU && cpu_grant_count != CNT_MAX)
                cpu_grant_count <= cpu_grant_count + 1'b1;
            if (winner == OWNER_LDR && ldr_grant_count != CNT_MAX)
                ldr_grant_count <= ldr_grant_count + 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
//------------------------------------------------------------------------------
// tb_ram_arbiter : directed self-checking bench for ram_arbiter with a local
//                  16x8 synchronous RAM model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [3:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic [7:0] cpu_rdata;
    logic       cpu_ack, cpu_stall;
    logic       ldr_req = 1'b0, ldr_we = 1'b0;
    logic [3:0] ldr_addr = '0;
    logic [7:0] ldr_wdata = '0;
    logic [7:0] ldr_rdata;
    logic       ldr_ack;
    logic       loader_mode = 1'b0;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = '0;
    logic [1:0] grant;
`ifdef RAM_ARBITER_PERF_COUNT_EN
    logic        count_clear = 1'b0;
    logic [15:0] cpu_grant_count, ldr_grant_count;
`endif

    logic [7:0] mem [16];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .cpu_stall   (cpu_stall),
        .ldr_req     (ldr_req),
        .ldr_we      (ldr_we),
        .ldr_addr    (ldr_addr),
        .ldr_wdata   (ldr_wdata),
        .ldr_rdata   (ldr_rdata),
        .ldr_ack     (ldr_ack),
        .loader_mode (loader_mode),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
`ifdef RAM_ARBITER_PERF_COUNT_EN
        .count_clear     (count_clear),
        .cpu_grant_count (cpu_grant_count),
        .ldr_grant_count (ldr_grant_count),
`endif
        .grant       (grant)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] rr_exp [8];
        rr_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // Reset held with a CPU write pending: RAM must stay quiet.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h3; cpu_wdata = 8'hA5;
        step(); step();
        check("rst_grant", grant, 2'b00);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);

        // First CPU write.
        reset = 1'b1;
        #1;
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, 4'h3);
        check("wr_ram_wdata", ram_wdata, 8'hA5);
        step();
        check("wr_grant", grant, 2'b01);
        check("wr_cpu_ack", cpu_ack, 1);
        check("wr_cpu_rdata", cpu_rdata, 0);
        check("wr_mem3", mem[3], 8'hA5);
        cpu_we = 1'b0;
        step();
        check("wr_idle_grant", grant, 2'b00);
        check("wr_idle_ack", cpu_ack, 0);
        check("wr_idle_stall", cpu_stall, 1);
        step();
        check("rd_cpu_ack", cpu_ack, 1);
        check("rd_cpu_rdata", cpu_rdata, 8'hA5);
        cpu_req = 1'b0;
        step();
        check("idle_ram_addr", ram_addr, 4'h0);
        check("idle_ram_we", ram_we, 0);

        // Both requesting from reset: alternating grants, CPU first.
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'h3;
        step();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("rr_grant%0d", i), grant, rr_exp[i]);
            check($sformatf("rr_cpu_ack%0d", i), cpu_ack, rr_exp[i] == 2'b01);
            check($sformatf("rr_ldr_ack%0d", i), ldr_ack, rr_exp[i] == 2'b10);
            if (rr_exp[i] == 2'b01) check($sformatf("rr_cpu_rdata%0d", i), cpu_rdata, 8'hA5);
            if (rr_exp[i] == 2'b10) check($sformatf("rr_ldr_rdata%0d", i), ldr_rdata, 8'hA5);
        end

        // Loader mode locks the CPU out while the loader writes.
        loader_mode = 1'b1; ldr_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("lm_cpu_ack", cpu_ack, 0);
            check("lm_cpu_stall", cpu_stall, 1);
        end
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'hF; ldr_wdata = 8'h3C;
        #1;
        check("lm_ram_addr", ram_addr, 4'hF);
        check("lm_ram_wdata", ram_wdata, 8'h3C);
        check("lm_ram_we", ram_we, 1);
        step();
        check("lm_ldr_ack", ldr_ack, 1);
        check("lm_grant", grant, 2'b10);
        check("lm_mem15", mem[15], 8'h3C);
        ldr_req = 1'b0;
        step();
        loader_mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (grant == 2'b01) break;
        end
        check("lm_release_grant", grant, 2'b01);
        check("lm_release_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        step();

        // Request dropped mid-transaction, loader_mode raised during S_CPU.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h5; cpu_wdata = 8'h11;
        step();
        cpu_req = 1'b0; loader_mode = 1'b1;
        #1;
        check("drop_cpu_ack", cpu_ack, 1);
        check("drop_cpu_stall", cpu_stall, 0);
        check("drop_mem5", mem[5], 8'h11);
        step();
        check("drop_idle_ack", cpu_ack, 0);
        loader_mode = 1'b0;

        // Asynchronous reset in S_LDR.
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'h7; ldr_wdata = 8'h55;
        step();
        check("ar_ldr_ack_pre", ldr_ack, 1);
        ldr_req = 1'b0;
        #2;
        reset = 1'b0;
        ldr_req = 1'b1;
        #1;
        check("ar_ldr_ack", ldr_ack, 0);
        check("ar_grant", grant, 2'b00);
        check("ar_ram_we", ram_we, 0);
        ldr_req = 1'b0;
        step();
        reset = 1'b1;

`ifdef RAM_ARBITER_PERF_COUNT_EN
        check("pc_rst_cpu", cpu_grant_count, 0);
        check("pc_rst_ldr", ldr_grant_count, 0);
        cpu_req = 1'b1; cpu_we = 1'b0;
        for (int i = 0; i < 10; i++) step();
        cpu_req = 1'b0; ldr_req = 1'b1; ldr_we = 1'b0;
        for (int i = 0; i < 6; i++) step();
        ldr_req = 1'b0;
        step();
        check("pc_cpu_count", cpu_grant_count, 5);
        check("pc_ldr_count", ldr_grant_count, 3);
        cpu_req = 1'b1; count_clear = 1'b1;
        step();
        check("pc_clear_grant", grant, 2'b01);
        check("pc_clear_cpu", cpu_grant_count, 0);
        check("pc_clear_ldr", ldr_grant_count, 0);
        cpu_req = 1'b0; count_clear = 1'b0;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
